// File: rtl/axi_ram_slave.sv
// axi_ram_slave: AXI3 slave serving single/burst reads and writes from an internal word RAM
module axi_ram_slave #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [3:0]  arlen,
  input  logic [1:0]  arburst,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awlen,
  input  logic [1:0]  awburst,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  typedef enum logic [2:0] {IDLE, RREQ, RDATA, WDATA, BRESP} state_t;
  state_t state;
  logic [31:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] idx, idx_nxt, wrap_mask;
  logic [3:0] len, cnt;
  logic [1:0] burst;
  logic prio_rd;
  logic wrap_ok;
  logic unused_addr_bits;
  assign unused_addr_bits = ^{araddr[31:ADDR_WIDTH+2], araddr[1:0], awaddr[31:ADDR_WIDTH+2], awaddr[1:0]};
  assign rresp = 2'b00;
  assign bresp = 2'b00;
  assign arready = state == IDLE && arvalid && (!awvalid || prio_rd);
  assign awready = state == IDLE && awvalid && (!arvalid || !prio_rd);
  // next word index: FIXED holds, WRAP on power-of-two lengths stays inside its block, else INCR
  always_comb begin
    wrap_mask = {{(ADDR_WIDTH-4){1'b0}}, len};
    wrap_ok = len != 4'd0 && (len & (len + 4'd1)) == 4'd0;
    idx_nxt = burst == 2'b00 ? idx
            : (burst == 2'b10 && wrap_ok) ? ((idx & ~wrap_mask) | ((idx + 1'b1) & wrap_mask))
            : idx + 1'b1;
  end
  // byte-strobed RAM write; contents are intentionally never reset
  always_ff @(posedge aclk)
    if (aresetn && state == WDATA && wvalid)
      for (int b = 0; b < 4; b++)
        if (wstrb[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
  // transaction FSM with registered channel outputs and read/write fairness
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state   <= IDLE;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      rid     <= 4'd0;
      bid     <= 4'd0;
      rdata   <= 32'd0;
      prio_rd <= 1'b1;
      idx     <= '0;
      len     <= 4'd0;
      cnt     <= 4'd0;
      burst   <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (arvalid && awvalid) prio_rd <= !prio_rd;
          if (arready) begin
            rid   <= arid;
            idx   <= araddr[ADDR_WIDTH+1:2];
            len   <= arlen;
            burst <= arburst;
            cnt   <= 4'd0;
            state <= RREQ;
          end else if (awready) begin
            bid    <= awid;
            idx    <= awaddr[ADDR_WIDTH+1:2];
            len    <= awlen;
            burst  <= awburst;
            cnt    <= 4'd0;
            wready <= 1'b1;
            state  <= WDATA;
          end
        end
        RREQ: begin
          rdata  <= mem[idx];
          rlast  <= cnt == len;
          rvalid <= 1'b1;
          state  <= RDATA;
        end
        RDATA: begin
          if (rready) begin
            rvalid <= 1'b0;
            rlast  <= 1'b0;
            idx    <= idx_nxt;
            cnt    <= cnt + 4'd1;
            state  <= rlast ? IDLE : RREQ;
          end
        end
        WDATA: begin
          if (wvalid) begin
            idx <= idx_nxt;
            cnt <= cnt + 4'd1;
            if (cnt == len) begin
              wready <= 1'b0;
              bvalid <= 1'b1;
              state  <= BRESP;
            end
          end
        end
        BRESP: begin
          if (bready) begin
            bvalid <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_ram_slave.sv
// tb_axi_ram_slave: directed checks of axi_ram_slave reads, writes, bursts, arbitration and reset
module tb_axi_ram_slave;
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic [3:0] arid = '0, awid = '0, arlen = '0, awlen = '0, wstrb = '0;
  logic [31:0] araddr = '0, awaddr = '0, wdata = '0;
  logic [1:0] arburst = '0, awburst = '0;
  logic arvalid = 1'b0, awvalid = 1'b0, wvalid = 1'b0, rready = 1'b0, bready = 1'b0;
  logic arready, awready, rlast, rvalid, wready, bvalid;
  logic [3:0] rid, bid;
  logic [31:0] rdata;
  logic [1:0] rresp, bresp;
  logic [31:0] wbuf [16];
  logic [31:0] ebuf [16];
  int tests = 0;
  int fails = 0;

  axi_ram_slave #(.ADDR_WIDTH(12)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [1:0] burst, input logic [3:0] strb);
    int n;
    @(negedge aclk);
    awid = id; awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
    n = 0;
    #1;
    while (!awready && n < 20) begin @(negedge aclk); #1; n++; end
    chk("aw_grant", awready, 1);
    @(negedge aclk);
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      chk("wready", wready, 1);
      wdata = wbuf[i]; wstrb = strb; wvalid = 1'b1;
      @(negedge aclk);
    end
    wvalid = 1'b0;
    chk("bvalid", bvalid, 1);
    chk("wready_low", wready, 0);
    chk("bid", bid, id);
    chk("bresp", bresp, 0);
    bready = 1'b1;
    @(negedge aclk);
    bready = 1'b0;
    chk("bvalid_clr", bvalid, 0);
  endtask

  task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [1:0] burst, input int hold);
    int n;
    @(negedge aclk);
    arid = id; araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1;
    n = 0;
    #1;
    while (!arready && n < 20) begin @(negedge aclk); #1; n++; end
    chk("ar_grant", arready, 1);
    @(negedge aclk);
    arvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      n = 0;
      while (!rvalid && n < 20) begin @(negedge aclk); n++; end
      chk("r_latency", n, 1);
      if (i == hold) begin
        repeat (3) @(negedge aclk);
        chk("hold_rvalid", rvalid, 1);
        chk("hold_rdata", rdata, ebuf[i]);
        chk("hold_rlast", rlast, 32'(i == int'(len)));
      end
      chk("rdata", rdata, ebuf[i]);
      chk("rlast", rlast, 32'(i == int'(len)));
      chk("rid", rid, id);
      chk("rresp", rresp, 0);
      rready = 1'b1;
      @(negedge aclk);
      rready = 1'b0;
    end
  endtask

  initial begin
    int n;
    repeat (3) @(negedge aclk);
    chk("rst_flags", {26'd0, arready, awready, rvalid, rlast, wready, bvalid}, 0);
    chk("rst_ids", {rid, bid}, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_resp", {rresp, bresp}, 0);
    aresetn = 1'b1;

    // simultaneous requests from reset: read, write, read
    @(negedge aclk);
    araddr = 32'h40; arlen = 4'd0; arburst = 2'b01; arid = 4'd1;
    awaddr = 32'h44; awlen = 4'd0; awburst = 2'b01; awid = 4'd2;
    wdata = 32'h0000_0055; wstrb = 4'hF; wvalid = 1'b1;
    rready = 1'b1; bready = 1'b1;
    arvalid = 1'b1; awvalid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      #1;
      while (!(arready || awready) && n < 20) begin @(negedge aclk); #1; n++; end
      chk("arb_ar", arready, 32'(k != 1));
      chk("arb_aw", awready, 32'(k == 1));
      @(negedge aclk);
    end
    arvalid = 1'b0; awvalid = 1'b0;
    repeat (4) @(negedge aclk);
    rready = 1'b0; bready = 1'b0; wvalid = 1'b0;
    ebuf[0] = 32'h0000_0055;
    axi_read(4'd7, 32'h44, 4'd0, 2'b01, -1);

    // single write then read
    wbuf[0] = 32'hDEADBEEF;
    axi_write(4'd5, 32'h10, 4'd0, 2'b01, 4'hF);
    ebuf[0] = 32'hDEADBEEF;
    axi_read(4'd9, 32'h10, 4'd0, 2'b01, -1);

    // partial strobes merge into existing word
    wbuf[0] = 32'h11223344;
    axi_write(4'd1, 32'h14, 4'd0, 2'b01, 4'hF);
    wbuf[0] = 32'hAABBCCDD;
    axi_write(4'd2, 32'h14, 4'd0, 2'b01, 4'h5);
    ebuf[0] = 32'h11BB33DD;
    axi_read(4'd3, 32'h14, 4'd0, 2'b01, -1);

    // INCR burst with master stall on beat 1
    wbuf[0] = 32'd1; wbuf[1] = 32'd2; wbuf[2] = 32'd3; wbuf[3] = 32'd4;
    axi_write(4'd4, 32'h20, 4'd3, 2'b01, 4'hF);
    ebuf[0] = 32'd1; ebuf[1] = 32'd2; ebuf[2] = 32'd3; ebuf[3] = 32'd4;
    axi_read(4'd6, 32'h20, 4'd3, 2'b01, 1);

    // WRAP and FIXED reads
    wbuf[0] = 32'hAAAA_000A; wbuf[1] = 32'hBBBB_000B; wbuf[2] = 32'hCCCC_000C; wbuf[3] = 32'hDDDD_000D;
    axi_write(4'd8, 32'h20, 4'd3, 2'b01, 4'hF);
    ebuf[0] = 32'hCCCC_000C; ebuf[1] = 32'hDDDD_000D; ebuf[2] = 32'hAAAA_000A; ebuf[3] = 32'hBBBB_000B;
    axi_read(4'd10, 32'h28, 4'd3, 2'b10, -1);
    ebuf[0] = 32'hCCCC_000C; ebuf[1] = 32'hCCCC_000C; ebuf[2] = 32'hCCCC_000C;
    axi_read(4'd11, 32'h28, 4'd2, 2'b00, -1);

    // WRAP write starting mid-block, read back linearly
    wbuf[0] = 32'hE0; wbuf[1] = 32'hE1; wbuf[2] = 32'hE2; wbuf[3] = 32'hE3;
    axi_write(4'd12, 32'h38, 4'd3, 2'b10, 4'hF);
    ebuf[0] = 32'hE2; ebuf[1] = 32'hE3; ebuf[2] = 32'hE0; ebuf[3] = 32'hE1;
    axi_read(4'd13, 32'h30, 4'd3, 2'b01, -1);

    // upper address bits alias onto the same word
    ebuf[0] = 32'hDEADBEEF;
    axi_read(4'd14, 32'h0000_4010, 4'd0, 2'b01, -1);

    // reset during beat 2 of a 4-beat read
    @(negedge aclk);
    araddr = 32'h20; arlen = 4'd3; arburst = 2'b01; arid = 4'd3; arvalid = 1'b1;
    #1;
    chk("rst_ar_grant", arready, 1);
    @(negedge aclk);
    arvalid = 1'b0;
    @(negedge aclk);
    chk("rst_beat0", rdata, 32'hAAAA_000A);
    rready = 1'b1;
    @(negedge aclk);
    rready = 1'b0;
    @(negedge aclk);
    chk("rst_beat1_valid", rvalid, 1);
    chk("rst_beat1", rdata, 32'hBBBB_000B);
    aresetn = 1'b0;
    @(negedge aclk);
    chk("abort_rvalid", rvalid, 0);
    chk("abort_rdata", rdata, 0);
    chk("abort_rid", rid, 0);
    aresetn = 1'b1;
    ebuf[0] = 32'hAAAA_000A; ebuf[1] = 32'hBBBB_000B; ebuf[2] = 32'hCCCC_000C; ebuf[3] = 32'hDDDD_000D;
    axi_read(4'd15, 32'h20, 4'd3, 2'b01, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
